// File: rtl/mcycle_controller.sv
// Multicycle MIPS controller: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// shared-memory request handshake and traps to ERR on a memory timeout.
module mcycle_controller #(
    parameter int unsigned ALUFN_W = 5,
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic               Z,
    input  logic               mem_rdy,
    output logic               mem_req,
    output logic               mem_wr,
    output logic               ir_we,
    output logic               pc_we,
    output logic               instr_done,
    output logic [1:0]         pcsel,
    output logic [1:0]         wasel,
    output logic [1:0]         wdsel,
    output logic [1:0]         asel,
    output logic               bsel,
    output logic               sext,
    output logic [ALUFN_W-1:0] alufn,
    output logic               werf,
    output logic [2:0]         state,
    output logic               bus_err
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR
    } cls_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_ADD  = 6'b100000;
    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUB  = 6'b100010;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;
    localparam logic [5:0] F_NOR  = 6'b100111;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    // ALU function encodings
    localparam logic [4:0] ALU_AND  = 5'b00000;
    localparam logic [4:0] ALU_ADD  = 5'b00001;
    localparam logic [4:0] ALU_SLL  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00100;
    localparam logic [4:0] ALU_XOR  = 5'b01000;
    localparam logic [4:0] ALU_SRL  = 5'b01010;
    localparam logic [4:0] ALU_NOR  = 5'b01100;
    localparam logic [4:0] ALU_SRA  = 5'b01110;
    localparam logic [4:0] ALU_SUB  = 5'b10001;
    localparam logic [4:0] ALU_SLT  = 5'b10011;
    localparam logic [4:0] ALU_SLTU = 5'b10111;

    localparam logic [1:0] ASEL_SHAMT = 2'b01;
    localparam logic [1:0] ASEL_C16   = 2'b10;

    // Last count value before a waiting request is declared timed out
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             req_pend_q;
    logic             bus_err_q;

    cls_t             d_cls;
    logic [4:0]       d_alu;
    logic [1:0]       d_asel;
    logic             d_bsel, d_sext;

    logic             mem_req_c, mem_wr_c, ir_we_c, pc_we_c, werf_c;
    logic [1:0]       pcsel_c, wasel_c, wdsel_c, asel_c;
    logic             bsel_c, sext_c;
    logic [4:0]       alu_c;

    // Instruction decode: class, ALU function and operand selects from op/func
    always_comb begin
        d_cls  = C_NOP;
        d_alu  = '0;
        d_asel = '0;
        d_bsel = 1'b0;
        d_sext = 1'b0;
        case (op)
            OP_RTYPE: begin
                case (func)
                    F_ADD, F_ADDU: begin d_cls = C_ALU; d_alu = ALU_ADD;  end
                    F_SUB, F_SUBU: begin d_cls = C_ALU; d_alu = ALU_SUB;  end
                    F_AND:         begin d_cls = C_ALU; d_alu = ALU_AND;  end
                    F_OR:          begin d_cls = C_ALU; d_alu = ALU_OR;   end
                    F_XOR:         begin d_cls = C_ALU; d_alu = ALU_XOR;  end
                    F_NOR:         begin d_cls = C_ALU; d_alu = ALU_NOR;  end
                    F_SLT:         begin d_cls = C_ALU; d_alu = ALU_SLT;  end
                    F_SLTU:        begin d_cls = C_ALU; d_alu = ALU_SLTU; end
                    F_SLL: begin d_cls = C_ALU; d_alu = ALU_SLL; d_asel = ASEL_SHAMT; end
                    F_SRL: begin d_cls = C_ALU; d_alu = ALU_SRL; d_asel = ASEL_SHAMT; end
                    F_SRA: begin d_cls = C_ALU; d_alu = ALU_SRA; d_asel = ASEL_SHAMT; end
                    F_JR:          d_cls = C_JR;
                    default: ;
                endcase
            end
            OP_J:     d_cls = C_J;
            OP_JAL:   d_cls = C_JAL;
            OP_BEQ:   begin d_cls = C_BEQ; d_alu = ALU_SUB; d_sext = 1'b1; end
            OP_BNE:   begin d_cls = C_BNE; d_alu = ALU_SUB; d_sext = 1'b1; end
            OP_ADDI, OP_ADDIU: begin
                d_cls = C_ALU; d_alu = ALU_ADD; d_bsel = 1'b1; d_sext = 1'b1;
            end
            OP_SLTI:  begin d_cls = C_ALU; d_alu = ALU_SLT;  d_bsel = 1'b1; d_sext = 1'b1; end
            OP_SLTIU: begin d_cls = C_ALU; d_alu = ALU_SLTU; d_bsel = 1'b1; d_sext = 1'b1; end
            OP_ANDI:  begin d_cls = C_ALU; d_alu = ALU_AND;  d_bsel = 1'b1; end
            OP_ORI:   begin d_cls = C_ALU; d_alu = ALU_OR;   d_bsel = 1'b1; end
            OP_XORI:  begin d_cls = C_ALU; d_alu = ALU_XOR;  d_bsel = 1'b1; end
            OP_LUI: begin
                d_cls = C_ALU; d_alu = ALU_SLL; d_asel = ASEL_C16; d_bsel = 1'b1;
            end
            OP_LW:    begin d_cls = C_LW; d_alu = ALU_ADD; d_bsel = 1'b1; d_sext = 1'b1; end
            OP_SW:    begin d_cls = C_SW; d_alu = ALU_ADD; d_bsel = 1'b1; d_sext = 1'b1; end
            default: ;
        endcase
    end

    // Next-state and control strobes for the current phase
    always_comb begin
        state_d   = state_q;
        mem_req_c = 1'b0;
        mem_wr_c  = 1'b0;
        ir_we_c   = 1'b0;
        pc_we_c   = 1'b0;
        werf_c    = 1'b0;
        pcsel_c   = 2'b00;
        wasel_c   = 2'b00;
        wdsel_c   = 2'b00;
        asel_c    = 2'b00;
        bsel_c    = 1'b0;
        sext_c    = 1'b0;
        alu_c     = '0;
        case (state_q)
            S_FETCH: begin
                // A request already raised stays up even if enable drops
                if (enable || req_pend_q) begin
                    mem_req_c = 1'b1;
                    if (mem_rdy) begin
                        ir_we_c = 1'b1;
                        state_d = S_DECODE;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                asel_c = d_asel;
                bsel_c = d_bsel;
                sext_c = d_sext;
                alu_c  = d_alu;
                case (d_cls)
                    C_BEQ: begin
                        pc_we_c = 1'b1;
                        pcsel_c = Z ? 2'b01 : 2'b00;
                        state_d = S_FETCH;
                    end
                    C_BNE: begin
                        pc_we_c = 1'b1;
                        pcsel_c = Z ? 2'b00 : 2'b01;
                        state_d = S_FETCH;
                    end
                    C_J: begin
                        pc_we_c = 1'b1;
                        pcsel_c = 2'b10;
                        state_d = S_FETCH;
                    end
                    C_JAL: begin
                        pc_we_c = 1'b1;
                        pcsel_c = 2'b10;
                        werf_c  = 1'b1;
                        wasel_c = 2'b10;
                        wdsel_c = 2'b00;
                        state_d = S_FETCH;
                    end
                    C_JR: begin
                        pc_we_c = 1'b1;
                        pcsel_c = 2'b11;
                        state_d = S_FETCH;
                    end
                    C_LW, C_SW: state_d = S_MEM;
                    C_ALU:      state_d = S_WB;
                    default: begin
                        pc_we_c = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                asel_c    = d_asel;
                bsel_c    = d_bsel;
                sext_c    = d_sext;
                alu_c     = d_alu;
                mem_req_c = 1'b1;
                mem_wr_c  = (d_cls == C_SW);
                if (mem_rdy) begin
                    if (d_cls == C_SW) begin
                        pc_we_c = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                asel_c  = d_asel;
                bsel_c  = d_bsel;
                sext_c  = d_sext;
                alu_c   = d_alu;
                werf_c  = 1'b1;
                pc_we_c = 1'b1;
                wdsel_c = (d_cls == C_LW) ? 2'b10 : 2'b01;
                wasel_c = (op == OP_RTYPE) ? 2'b00 : 2'b01;
                state_d = S_FETCH;
            end
            default: state_d = S_ERR;
        endcase
    end

    // State, timeout counter, pending-fetch flag and sticky bus error
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_FETCH;
            cnt_q      <= '0;
            req_pend_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q)
                cnt_q <= '0;
            else if (mem_req_c && !mem_rdy)
                cnt_q <= cnt_q + 1'b1;
            req_pend_q <= (state_q == S_FETCH) && (state_d == S_FETCH) && mem_req_c;
            if (state_d == S_ERR)
                bus_err_q <= 1'b1;
        end
    end

    // Strobes are forced low while reset is asserted so an aborted instruction never commits
    assign mem_req    = mem_req_c & reset_n;
    assign mem_wr     = mem_wr_c  & reset_n;
    assign ir_we      = ir_we_c   & reset_n;
    assign pc_we      = pc_we_c   & reset_n;
    assign werf       = werf_c    & reset_n;
    assign instr_done = pc_we;
    assign pcsel      = pcsel_c;
    assign wasel      = wasel_c;
    assign wdsel      = wdsel_c;
    assign asel       = asel_c;
    assign bsel       = bsel_c;
    assign sext       = sext_c;
    assign alufn      = ALUFN_W'(alu_c);
    assign state      = state_q;
    assign bus_err    = bus_err_q;

endmodule
